usb_ep0_in_packetizer: RTL and testbench
========================================

Name: usb_ep0_in_packetizer

Overview:
- Downstream of the descriptor ROM stage on the EP0 control-IN path.
- Consumes the ROM byte stream (valid/data/last/nomatch), truncates it to the host's wLength, and splits it into packets of at most MPS bytes.
- Holds each packet in a local buffer so it can be replayed on host retry; inserts a ZLP when the data ends on a packet boundary short of wLength.
- Output feeds the SIE transmit path.

Parameters:
- MPS, 64, EP0 max packet size in bytes; power of two, 8..64.
- CNT_W, 7, packet byte-counter width; holds 0..MPS (log2(MPS)+1).
- LEN_W, 16, wLength/remaining-counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  pulse; latch wlength and begin a transfer (same cycle as the ROM request)
- wlength  in  LEN_W  host-requested length from the SETUP packet
- abort  in  1  pulse; new SETUP or bus reset; drop the transfer
- in_valid  in  1  ROM byte valid
- in_data  in  8  ROM byte
- in_last  in  1  final ROM byte of the descriptor
- in_nomatch  in  1  ROM lookup failed
- in_ready  out  1  byte accepted when in_valid && in_ready
- tx_req  in  1  pulse; IN token for EP0, transmit the current packet
- tx_valid  out  1  packet byte valid
- tx_data  out  8  packet byte
- tx_last  out  1  final byte of the packet; with tx_zlp, marks an empty packet
- tx_zlp  out  1  current packet has zero length (tx_valid=1, tx_last=1, tx_data ignored)
- tx_ready  in  1  SIE accepts a byte
- tx_ack  in  1  pulse; host ACKed the last packet
- tx_retry  in  1  pulse; no ACK, replay the packet
- stall  out  1  one-cycle pulse; EP0 must STALL (nomatch)
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse; final packet ACKed

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE. in_ready, tx_valid, tx_last, tx_zlp, stall, done, busy=0. All counters cleared.
- States: IDLE, FILL, DRAIN, READY, SEND, WAIT_ACK.
- IDLE, start=1: remaining<=wlength, src_done<=0, cnt<=0, busy<=1, go to FILL. If wlength==0, go to READY with cnt=0 (status-style ZLP).
- FILL: in_ready=1. Each accepted byte is written to buf[cnt], cnt++, remaining--.
  - in_last accepted: set src_done.
  - Packet closes on the byte where cnt reaches MPS, remaining reaches 0, or in_last. Go to READY.
  - If remaining reaches 0 and in_last has not been seen, go to DRAIN instead.
  - Entering FILL with src_done=1 or remaining==0: go to READY with cnt=0 (ZLP) without accepting input.
- DRAIN: in_ready=1, bytes discarded. On in_last, go to READY. The ROM must never be left stalled mid-stream.
- in_nomatch, while in FILL: stall pulse, busy<=0, go to IDLE.
- READY: wait for tx_req, then rd_ptr<=0, go to SEND.
- SEND: tx_valid=1. tx_data=buf[rd_ptr] (combinational/distributed read, zero added latency). tx_last=(rd_ptr==cnt-1) or cnt==0; tx_zlp=(cnt==0).
  - On tx_valid && tx_ready: rd_ptr++. The last byte goes to WAIT_ACK.
- WAIT_ACK:
  - tx_retry: go to READY; the same buffer content is replayed byte-identically.
  - tx_ack: if cnt<MPS, or (remaining==0 and cnt==MPS), the transfer is complete: done pulse, busy<=0, IDLE. Otherwise cnt<=0 and go to FILL for the next packet.
  - The ZLP rule follows: a full packet with src_done and remaining>0 leads to an empty packet next.
  - tx_ack and tx_retry in the same cycle: ack wins.
- abort in any state: IDLE next cycle, outputs deasserted, no done/stall. A ROM stream still in flight is ignored because in_ready=0. The upstream ROM restarts on its own next request.
- start while busy: treated as abort followed by start in the same cycle.
- tx_req outside READY: ignored. tx_ack/tx_retry outside WAIT_ACK: ignored.
- Width: remaining saturates at 0 and never wraps. A 16-bit wLength larger than the descriptor is legal.

Decomposition:
- Shared usb_ep0_pkg: state encodings, the EP0 MPS constants (8/64), and the clog2 helper for CNT_W.
- One sub-module, usb_ep0_pktbuf: MPS x 8 distributed RAM, synchronous write, asynchronous read.

Test Plan:
- Device descriptor 18 B, wlength=0x40, MPS=64 -> one 18-byte packet, tx_last on byte 17, done after tx_ack, no ZLP.
- Config descriptor 32 B, wlength=9 -> one 9-byte packet. The remaining 23 ROM bytes are drained (in_ready held to in_last). done after ack.
- 64 B descriptor, wlength=64 -> one 64-byte packet, then done, no ZLP. Same with wlength=255 -> 64-byte packet, then a ZLP (tx_zlp=1) on the next tx_req, done after its ack.
- MPS=8, 18 B descriptor, wlength=0xFF; tx_retry after packet 2 -> packets of 8/8/2 bytes, packet 2 replayed identically, done after the third ack.
- in_nomatch during FILL -> single-cycle stall pulse, tx_valid never asserted, busy=0.
- reset_n=0 or abort mid-SEND on byte 5 -> next cycle state IDLE, tx_valid=0. A fresh start yields correct packet 1 from byte 0.

Source files
------------

// File: rtl/usb_ep0_pkg.sv
// Shared EP0 definitions: packetizer state encoding, max-packet-size constants
// and a constant-evaluable ceil(log2) used to size the packet byte counter.
package usb_ep0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_READY,
        ST_SEND,
        ST_WAIT_ACK
    } ep0_state_t;

    localparam int unsigned EP0_MPS_LS = 8;
    localparam int unsigned EP0_MPS_FS = 64;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/usb_ep0_in_packetizer_if.sv
// Control, ROM byte stream and SIE transmit signals of the EP0 IN packetizer.
// master = surrounding logic (ROM, SETUP decoder, SIE); slave = packetizer.
interface usb_ep0_in_packetizer_if #(
    parameter int unsigned LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] wlength;
    logic             abort;

    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_nomatch;
    logic             in_ready;

    logic             tx_req;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             tx_zlp;
    logic             tx_ready;
    logic             tx_ack;
    logic             tx_retry;

    logic             stall;
    logic             busy;
    logic             done;

    modport master (
        output start, wlength, abort,
        output in_valid, in_data, in_last, in_nomatch,
        input  in_ready,
        output tx_req, tx_ready, tx_ack, tx_retry,
        input  tx_valid, tx_data, tx_last, tx_zlp,
        input  stall, busy, done
    );

    modport slave (
        input  start, wlength, abort,
        input  in_valid, in_data, in_last, in_nomatch,
        output in_ready,
        input  tx_req, tx_ready, tx_ack, tx_retry,
        output tx_valid, tx_data, tx_last, tx_zlp,
        output stall, busy, done
    );
endinterface

// File: rtl/usb_ep0_pktbuf.sv
// EP0 packet buffer: DEPTH x 8 distributed RAM, synchronous write, asynchronous read
// so the transmit side sees the addressed byte with no added latency.
module usb_ep0_pktbuf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/usb_ep0_in_packetizer.sv
// EP0 control-IN packetizer: truncates the descriptor stream to wLength, splits it
// into MPS-byte packets held for replay on retry, and appends a ZLP when needed.
module usb_ep0_in_packetizer
    import usb_ep0_pkg::*;
#(
    parameter int unsigned MPS   = EP0_MPS_FS,
    parameter int unsigned CNT_W = clog2(MPS) + 1,
    parameter int unsigned LEN_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    usb_ep0_in_packetizer_if.slave bus
);
    localparam int unsigned      AW        = CNT_W - 1;
    localparam logic [CNT_W-1:0] MPS_CNT   = CNT_W'(MPS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MPS - 1);

    ep0_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, rd_ptr;
    logic [LEN_W-1:0] remaining;
    logic             src_done, stall_q, done_q;
    logic             in_ready, tx_valid, tx_last, tx_zlp;
    logic             wr_en, load, cnt_clr, rd_clr, rd_inc, stall_n, done_n;
    logic [7:0]       rd_data;

    // start outranks abort and the current state: a restart while busy drops the old transfer.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_zlp   = 1'b0;
        wr_en    = 1'b0;
        load     = 1'b0;
        cnt_clr  = 1'b0;
        rd_clr   = 1'b0;
        rd_inc   = 1'b0;
        stall_n  = 1'b0;
        done_n   = 1'b0;

        if (bus.start) begin
            load    = 1'b1;
            state_n = (bus.wlength == '0) ? ST_READY : ST_FILL;
        end else if (bus.abort) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state_n = ST_IDLE;
                ST_FILL: begin
                    if (bus.in_nomatch) begin
                        stall_n = 1'b1;
                        state_n = ST_IDLE;
                    end else if (src_done || remaining == '0) begin
                        state_n = ST_READY;
                    end else begin
                        in_ready = 1'b1;
                        if (bus.in_valid) begin
                            wr_en = 1'b1;
                            if (remaining == LEN_W'(1) && !bus.in_last)
                                state_n = ST_DRAIN;
                            else if (bus.in_last || remaining == LEN_W'(1) || cnt == LAST_SLOT)
                                state_n = ST_READY;
                        end
                    end
                end
                ST_DRAIN: begin
                    in_ready = 1'b1;
                    if (bus.in_valid && bus.in_last) state_n = ST_READY;
                end
                ST_READY: begin
                    if (bus.tx_req) begin
                        rd_clr  = 1'b1;
                        state_n = ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_valid = 1'b1;
                    tx_zlp   = (cnt == '0);
                    tx_last  = tx_zlp || (rd_ptr == cnt - CNT_W'(1));
                    if (bus.tx_ready) begin
                        rd_inc = 1'b1;
                        if (tx_last) state_n = ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.tx_ack) begin
                        if (cnt < MPS_CNT || remaining == '0) begin
                            done_n  = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            cnt_clr = 1'b1;
                            state_n = ST_FILL;
                        end
                    end else if (bus.tx_retry) begin
                        state_n = ST_READY;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            src_done  <= 1'b0;
            stall_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state   <= state_n;
            stall_q <= stall_n;
            done_q  <= done_n;
            if (load) begin
                remaining <= bus.wlength;
                src_done  <= 1'b0;
                cnt       <= '0;
            end else if (wr_en) begin
                cnt       <= cnt + CNT_W'(1);
                remaining <= (remaining == '0) ? '0 : remaining - LEN_W'(1);
                if (bus.in_last) src_done <= 1'b1;
            end else if (cnt_clr) begin
                cnt <= '0;
            end
            if (rd_clr)      rd_ptr <= '0;
            else if (rd_inc) rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    usb_ep0_pktbuf #(
        .DEPTH (MPS),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (cnt[AW-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign bus.in_ready = in_ready;
    assign bus.tx_valid = tx_valid;
    assign bus.tx_data  = rd_data;
    assign bus.tx_last  = tx_last;
    assign bus.tx_zlp   = tx_zlp;
    assign bus.stall    = stall_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state != ST_IDLE);
endmodule

// File: tb/tb_usb_ep0_in_packetizer.sv
// Bench for usb_ep0_in_packetizer: an MPS=64 and an MPS=8 instance share one stimulus
// path selected by sel; expected packets come from a slicing model of the descriptor.
module tb_usb_ep0_in_packetizer;
    import usb_ep0_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        start, abort, in_valid, in_last, in_nomatch;
    logic        tx_req, tx_ready, tx_ack, tx_retry;
    logic [15:0] wlength;
    logic [7:0]  in_data;
    logic        in_ready, tx_valid, tx_last, tx_zlp, stall, busy, done;
    logic [7:0]  tx_data;
    logic [7:0]  desc [256];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    usb_ep0_in_packetizer_if #(.LEN_W(16)) if64 ();
    usb_ep0_in_packetizer_if #(.LEN_W(16)) if8 ();

    assign if64.start = start && !sel;
    assign if8.start  = start && sel;
    assign if64.wlength = wlength;     assign if8.wlength = wlength;
    assign if64.abort = abort;         assign if8.abort = abort;
    assign if64.in_valid = in_valid;   assign if8.in_valid = in_valid;
    assign if64.in_data = in_data;     assign if8.in_data = in_data;
    assign if64.in_last = in_last;     assign if8.in_last = in_last;
    assign if64.in_nomatch = in_nomatch; assign if8.in_nomatch = in_nomatch;
    assign if64.tx_req = tx_req;       assign if8.tx_req = tx_req;
    assign if64.tx_ready = tx_ready;   assign if8.tx_ready = tx_ready;
    assign if64.tx_ack = tx_ack;       assign if8.tx_ack = tx_ack;
    assign if64.tx_retry = tx_retry;   assign if8.tx_retry = tx_retry;

    assign in_ready = sel ? if8.in_ready : if64.in_ready;
    assign tx_valid = sel ? if8.tx_valid : if64.tx_valid;
    assign tx_data  = sel ? if8.tx_data  : if64.tx_data;
    assign tx_last  = sel ? if8.tx_last  : if64.tx_last;
    assign tx_zlp   = sel ? if8.tx_zlp   : if64.tx_zlp;
    assign stall    = sel ? if8.stall    : if64.stall;
    assign busy     = sel ? if8.busy     : if64.busy;
    assign done     = sel ? if8.done     : if64.done;

    usb_ep0_in_packetizer #(.MPS(EP0_MPS_FS)) u_dut64 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if64.slave)
    );

    usb_ep0_in_packetizer #(.MPS(EP0_MPS_LS)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if8.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; in_valid = 0; in_last = 0; in_nomatch = 0;
        tx_req = 0; tx_ready = 0; tx_ack = 0; tx_retry = 0; in_data = '0;
    endtask

    // Whole control-IN transfer with a random ROM pacing and random SIE back-pressure.
    task automatic run_xfer(input int s, input int len, input int wl, input int retry_pkt);
        int m, n, rom_ptr, pkt_idx, cyc, exp_len, bad, idx;
        int plen[$];
        logic [7:0] rx[$];
        bit ack_pending, do_retry, retried, done_seen, stall_seen;
        m = (s != 0) ? 8 : 64;
        for (int i = 0; i < len; i++) desc[i] = 8'($urandom);
        n = (len < wl) ? len : wl;
        for (int off = 0; off < n; off += m) plen.push_back(((n - off) < m) ? (n - off) : m);
        if (n == 0 || (n % m == 0 && n < wl)) plen.push_back(0);
        rom_ptr = 0; pkt_idx = 0; cyc = 0;
        ack_pending = 0; do_retry = 0; retried = 0; done_seen = 0; stall_seen = 0;

        sel = s[0];
        idle_inputs();
        start = 1; wlength = 16'(wl);
        @(negedge clk);
        start = 0;
        while (!done_seen && cyc < 3000) begin
            tx_ack = 0; tx_retry = 0; tx_req = 0;
            if (ack_pending) begin
                if (do_retry) tx_retry = 1;
                else begin
                    tx_ack = 1;
                    pkt_idx++;
                end
                ack_pending = 0;
            end else begin
                tx_req = ($urandom % 2) == 0;
            end
            tx_ready = ($urandom % 4) != 0;
            in_valid = (rom_ptr < len) && (($urandom % 4) != 0);
            in_data  = desc[rom_ptr % 256];
            in_last  = (rom_ptr == len - 1);
            #1;
            if (in_valid && in_ready) rom_ptr++;
            if (done) done_seen = 1;
            if (stall) stall_seen = 1;
            if (tx_valid && tx_ready) begin
                if (!tx_zlp) rx.push_back(tx_data);
                if (tx_last || rx.size() > m) begin
                    exp_len = (pkt_idx < plen.size()) ? plen[pkt_idx] : -1;
                    check("pkt_len", rx.size(), exp_len);
                    check("pkt_zlp", tx_zlp, exp_len == 0);
                    bad = 0;
                    foreach (rx[i]) begin
                        idx = pkt_idx * m + i;
                        if (idx >= 256 || rx[i] !== desc[idx]) bad++;
                    end
                    check("pkt_data", bad, 0);
                    do_retry = (pkt_idx == retry_pkt) && !retried;
                    if (do_retry) retried = 1;
                    ack_pending = 1;
                    rx.delete();
                end
            end
            cyc++;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        check("done_seen", done_seen, 1);
        check("pkt_count", pkt_idx, plen.size());
        check("retry_used", retried, (retry_pkt >= 0) && (retry_pkt < plen.size()));
        check("no_stall", stall_seen, 0);
        check("rom_drained", rom_ptr, (wl == 0) ? 0 : len);
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        @(negedge clk);
    endtask

    task automatic nomatch_test();
        int stalls, valids;
        stalls = 0; valids = 0;
        sel = 0;
        idle_inputs();
        start = 1; wlength = 16'h40;
        @(negedge clk);
        start = 0;
        #1;
        check("nm_busy", busy, 1);
        check("nm_in_ready", in_ready, 1);
        in_nomatch = 1;
        @(negedge clk);
        in_nomatch = 0;
        #1;
        check("nm_stall", stall, 1);
        check("nm_busy_clr", busy, 0);
        if (tx_valid) valids++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_req = 1; tx_ready = 1;
            #1;
            if (stall) stalls++;
            if (tx_valid) valids++;
        end
        idle_inputs();
        check("nm_stall_once", stalls, 0);
        check("nm_no_tx", valids, 0);
        @(negedge clk);
    endtask

    // Stops a SEND with byte 5 on the bus, either by abort or by synchronous reset.
    task automatic kill_mid_send(input bit use_reset);
        int txc, cyc, rp;
        txc = 0; cyc = 0; rp = 0;
        for (int i = 0; i < 18; i++) desc[i] = 8'($urandom);
        sel = 0;
        idle_inputs();
        start = 1; wlength = 16'h40;
        @(negedge clk);
        start = 0;
        while (txc < 5 && cyc < 300) begin
            in_valid = rp < 18; in_data = desc[rp % 256]; in_last = (rp == 17);
            tx_req = 1; tx_ready = 1;
            #1;
            if (in_valid && in_ready) rp++;
            if (tx_valid && tx_ready) txc++;
            cyc++;
            @(negedge clk);
        end
        idle_inputs();
        #1;
        check("kill_pre_valid", tx_valid, 1);
        check("kill_pre_byte5", tx_data, desc[5]);
        if (use_reset) reset_n = 0;
        else abort = 1;
        @(negedge clk);
        reset_n = 1; abort = 0;
        #1;
        check("kill_tx_valid", tx_valid, 0);
        check("kill_busy", busy, 0);
        check("kill_in_ready", in_ready, 0);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        wlength = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_in_ready", in_ready, 0);
            check("rst_tx_valid", tx_valid, 0);
            check("rst_tx_last", tx_last, 0);
            check("rst_tx_zlp", tx_zlp, 0);
            check("rst_busy", busy, 0);
            check("rst_stall", stall, 0);
            check("rst_done", done, 0);
        end
        reset_n = 1;
        @(negedge clk);

        run_xfer(0, 18, 16'h40, -1);
        run_xfer(0, 32, 9, -1);
        run_xfer(0, 64, 64, -1);
        run_xfer(0, 64, 255, -1);
        run_xfer(1, 18, 16'hFF, 1);
        run_xfer(0, 20, 0, -1);
        run_xfer(1, 16, 100, -1);
        run_xfer(1, 8, 8, 0);
        nomatch_test();
        kill_mid_send(0);
        run_xfer(0, 18, 16'h40, -1);
        kill_mid_send(1);
        run_xfer(0, 18, 16'h40, -1);
        for (int k = 0; k < 6; k++)
            run_xfer(k % 2, int'($urandom_range(1, 100)), int'($urandom_range(0, 130)),
                     int'($urandom_range(0, 3)) - 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
